// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types, sizes and the power-up register value for the write-back controller.
package regfile_wb_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int DATA_W   = 32;

    // Register n powers up holding its decimal digits as hex nibbles (31 -> 0x31).
    function automatic logic [DATA_W-1:0] init_value(input logic [IDX_W-1:0] idx);
        int unsigned v;
        v = 32'(idx);
        return DATA_W'(((v / 10) << 4) | (v % 10));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding pending load results; DEPTH must be a power of two.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back arbiter: power-up init sweep, then ALU and buffered load results.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int LD_DEPTH = 2,
    parameter int INIT_EN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [IDX_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [IDX_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              regwrite,
    output logic [IDX_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_busy
);
    localparam int CNT_W = $clog2(LD_DEPTH) + 1;
    localparam int ENT_W = IDX_W + DATA_W;

    state_t            state;
    logic [IDX_W-1:0]  init_idx;
    logic              run;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  ld_count;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign run       = (state == ST_RUN) && !reset;
    // Readiness looks at occupancy at the start of the cycle, never at this cycle's pop.
    assign ld_ready  = run && (ld_count < CNT_W'(LD_DEPTH));
    assign alu_ready = run && !fifo_full;
    assign init_busy = (state == ST_INIT);
    assign push      = ld_valid && ld_ready;

    wb_fifo #(
        .DEPTH (LD_DEPTH),
        .W     (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({ld_rd, ld_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (ld_count)
    );

    // A full buffer outranks the ALU so loads cannot starve behind a busy ALU.
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (run) begin
            if (fifo_full || (!alu_valid && !fifo_empty)) begin
                pop       = 1'b1;
                sel_valid = 1'b1;
                {sel_rd, sel_data} = head;
            end else if (alu_valid) begin
                sel_valid = 1'b1;
                sel_rd    = alu_rd;
                sel_data  = alu_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_idx   <= '0;
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            regwrite <= 1'b0;
            case (state)
                ST_INIT: begin
                    regwrite   <= 1'b1;
                    write_reg  <= init_idx;
                    write_data <= init_value(init_idx);
                    init_idx   <= init_idx + 1'b1;
                    if (init_idx == IDX_W'(NUM_REGS - 1)) state <= ST_RUN;
                end
                default: begin
                    // Writes to x0 are consumed silently; only the sweep touches it.
                    if (sel_valid && (sel_rd != '0)) begin
                        regwrite   <= 1'b1;
                        write_reg  <= sel_rd;
                        write_data <= sel_data;
                    end
                end
            endcase
        end
    end

endmodule
